// File: rtl/loader_pkg.sv
// Shared types and helpers for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_CHK,
    S_RUN,
    S_ERR
  } loader_state_t;

  localparam int FRAME_MAX = 256;

  // A frame is good when the payload sum plus the check byte wraps to zero.
  function automatic logic chk_ok(input logic [7:0] sum, input logic [7:0] chk);
    logic [7:0] total;
    total = sum + chk;
    return (total == 8'd0);
  endfunction

endpackage

// File: rtl/program_loader.sv
// Loads a LEN/payload/CHK frame into program memory, then releases the CPU reset.
// Writes lag accepted payload bytes by one cycle; in_ready drops outside framing states or on load_req.
module program_loader
  import loader_pkg::*;
#(
  parameter int              ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] LOAD_BASE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              load_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  loader_state_t     state_q, state_d;
  logic [8:0]        remaining_q, remaining_d;
  logic [7:0]        sum_q, sum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              accept;

  assign in_ready = ((state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK)) && !load_req;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    sum_d       = sum_q;
    addr_d      = addr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;

    if (load_req) begin
      state_d     = S_LEN;
      remaining_d = '0;
      sum_d       = '0;
      addr_d      = LOAD_BASE;
      cpu_reset_d = 1'b1;
      done_d      = 1'b0;
      error_d     = 1'b0;
    end else if (accept) begin
      unique case (state_q)
        S_LEN: begin
          // LEN of zero encodes a full-size frame.
          remaining_d = (in_data == 8'd0) ? 9'(FRAME_MAX) : {1'b0, in_data};
          sum_d       = '0;
          addr_d      = LOAD_BASE;
          state_d     = S_DATA;
        end
        S_DATA: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = in_data;
          addr_d      = addr_q + ADDR_W'(1);
          sum_d       = sum_q + in_data;
          remaining_d = remaining_q - 9'd1;
          if (remaining_q == 9'd1) begin
            state_d = S_CHK;
          end
        end
        S_CHK: begin
          if (chk_ok(sum_q, in_data)) begin
            state_d     = S_RUN;
            cpu_reset_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_LEN;
      remaining_q <= '0;
      sum_q       <= '0;
      addr_q      <= LOAD_BASE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= LOAD_BASE;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      sum_q       <= sum_d;
      addr_q      <= addr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
